if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with an integrated prefetch queue and IF/ID output register for the ARM pipeline. It decouples instruction memory latency from the decode stage. It issues sequential fetches through a req/ack handshake, buffers up to DEPTH instructions, and implements freeze, flush and branch redirect. Its outputs feed ID directly. There is no separate stage-register block.

---
 rtl/if_prefetch_unit.sv | 160 ++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: sequential fetch engine over a req/ack memory port,
// a small circular prefetch queue, and the IF/ID output register feeding decode.
// Handles freeze (decode stall), flush (kill output) and branch redirect.
module if_prefetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     freeze,
   input  logic                     flush,
   input  logic                     branch_taken,
   input  logic [ADDR_W-1:0]        branch_addr,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_ack,
   input  logic [DATA_W-1:0]        imem_rdata,
   output logic [ADDR_W-1:0]        PC,
   output logic [DATA_W-1:0]        Instruction,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   // queue entry: PC value presented to decode plus the instruction word
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   // IDLE: nothing outstanding; WAIT: response gets queued; DROP: response discarded
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   entry_t            mem_q [DEPTH];
   entry_t            push_entry;

   logic              push, pop;
   logic [CNT_W-1:0]  occ_np;
   logic              space_idle, space_push;

   // Decode consumes the head only when nothing kills or stalls the output register.
   assign pop = !branch_taken && !flush && !freeze && (cnt_q != '0);

   // Next-cycle occupancy ignoring any push; the issue decisions add the push term.
   assign occ_np     = cnt_q - CNT_W'(pop);
   assign space_idle = occ_np < DEPTH_C;
   assign space_push = (occ_np + CNT_W'(1)) < DEPTH_C;

   assign push_entry = '{pc: fetch_pc_q + STEP_C, instr: imem_rdata};

   // Fetch FSM next-state: issue, push, redirect and response-drop decisions.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      push       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (branch_taken) begin
               fetch_pc_d = branch_addr;
            end else if (space_idle) begin
               addr_d  = fetch_pc_q;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken) begin
               // response in flight belongs to the wrong path
               fetch_pc_d = branch_addr;
               state_d    = imem_ack ? S_IDLE : S_DROP;
            end else if (imem_ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + STEP_C;
               if (space_push) begin
                  addr_d = fetch_pc_q + STEP_C;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (branch_taken) fetch_pc_d = branch_addr;
            if (imem_ack)     state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Fetch FSM state, fetch PC and latched request address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   assign imem_req  = (state_q != S_IDLE);
   assign imem_addr = addr_q;

   // Queue pointers and occupancy; a branch empties the queue outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (branch_taken) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Queue storage; contents are only meaningful under the occupancy count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign q_count = cnt_q;

   // IF/ID output register: kill beats stall, stall beats pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC          <= '0;
         Instruction <= '0;
         valid       <= 1'b0;
      end else if (branch_taken || flush) begin
         valid <= 1'b0;
      end else if (freeze) begin
         valid <= valid;
      end else if (cnt_q != '0) begin
         PC          <= mem_q[rd_ptr_q].pc;
         Instruction <= mem_q[rd_ptr_q].instr;
         valid       <= 1'b1;
      end else begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: zero-wait and slow memory, freeze,
// flush, branch redirect (with and without coincident ack) and async reset.
module tb_if_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0, flush = 1'b0, branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata, PC, Instruction;
   logic        valid;
   logic [2:0]  q_count;

   int total = 0;
   int bad   = 0;

   // memory model: ack after mem_lat wait cycles, or manual ack when mem_on=0
   int   mem_lat = 0;
   bit   mem_on  = 1'b1;
   logic man_ack = 1'b0;
   int   wcnt;

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst)                        wcnt <= 0;
      else if (!imem_req || imem_ack) wcnt <= 0;
      else                            wcnt <= wcnt + 1;
   end

   assign imem_ack   = mem_on ? (imem_req && (wcnt >= mem_lat)) : man_ack;
   assign imem_rdata = imem_addr | 32'hE000_0000;

   if_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .branch_taken(branch_taken), .branch_addr(branch_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .PC(PC), .Instruction(Instruction),
      .valid(valid), .q_count(q_count)
   );

   // reset pulse; returns at the negedge just before the first post-reset edge
   task automatic do_reset();
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      @(negedge clk);
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", PC); end
      total++; if (Instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", Instruction); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid); end
      total++; if (q_count !== 3'd0) begin bad++; $display("FAIL rst_qcount got=%0d exp=0", q_count); end
      rst = 1'b0;
   endtask

   // zero-wait stream; leaves the DUT at k=7 (PC=24, addr=28)
   task automatic test_zero_wait();
      mem_on = 1'b1; mem_lat = 0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++; if (imem_addr !== 32'(4*k)) begin bad++; $display("FAIL zw_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(4*k)); end
         if (k < 2) begin
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL zw_novalid k=%0d got=%0b exp=0", k, valid); end
         end else begin
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL zw_valid k=%0d got=%0b exp=1", k, valid); end
            total++; if (PC !== 32'(4*(k-1))) begin bad++; $display("FAIL zw_pc k=%0d got=%h exp=%h", k, PC, 32'(4*(k-1))); end
            total++; if (Instruction !== (32'hE000_0000 | 32'(4*(k-2)))) begin bad++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, Instruction, 32'hE000_0000 | 32'(4*(k-2))); end
         end
      end
   endtask

   // continues from test_zero_wait
   task automatic test_freeze();
      freeze = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++; if (PC !== 32'd24 || valid !== 1'b1) begin bad++; $display("FAIL frz_hold i=%0d got pc=%h v=%0b exp pc=18 v=1", i, PC, valid); end
      end
      total++; if (q_count !== 3'd4) begin bad++; $display("FAIL frz_qfull got=%0d exp=4", q_count); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL frz_req got=%0b exp=0", imem_req); end
      freeze = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         total++; if (valid !== 1'b1 || PC !== 32'(24+4*j)) begin bad++; $display("FAIL frz_rel_pc j=%0d got=%h v=%0b exp=%h", j, PC, valid, 32'(24+4*j)); end
         total++; if (Instruction !== (32'hE000_0000 | 32'(20+4*j))) begin bad++; $display("FAIL frz_rel_instr j=%0d got=%h exp=%h", j, Instruction, 32'hE000_0000 | 32'(20+4*j)); end
      end
   endtask

   task automatic test_latency();
      bit exp_v;
      mem_on = 1'b1; mem_lat = 3;
      do_reset();
      for (int m = 1; m <= 20; m++) begin
         @(negedge clk);
         exp_v = (m >= 6) && (((m - 6) % 4) == 0);
         total++; if (imem_addr !== 32'(4*((m-1)/4))) begin bad++; $display("FAIL lat_addr m=%0d got=%h exp=%h", m, imem_addr, 32'(4*((m-1)/4))); end
         total++; if (valid !== exp_v) begin bad++; $display("FAIL lat_valid m=%0d got=%0b exp=%0b", m, valid, exp_v); end
         if (exp_v) begin
            total++; if (PC !== 32'(4 + m - 6)) begin bad++; $display("FAIL lat_pc m=%0d got=%h exp=%h", m, PC, 32'(4 + m - 6)); end
         end
      end
      mem_lat = 0;
   endtask

   task automatic test_branch();
      mem_on = 1'b1; mem_lat = 0;
      do_reset();
      for (int k = 0; k <= 6; k++) @(negedge clk);
      total++; if (imem_addr !== 32'h18) begin bad++; $display("FAIL br_pre_addr got=%h exp=18", imem_addr); end
      mem_on = 1'b0; man_ack = 1'b0;
      branch_taken = 1'b1; branch_addr = 32'h100;
      @(negedge clk);
      branch_taken = 1'b0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%0b exp=0", valid); end
      total++; if (q_count !== 3'd0) begin bad++; $display("FAIL br_qcount got=%0d exp=0", q_count); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin bad++; $display("FAIL br_drop_req got req=%0b addr=%h exp 1/18", imem_req, imem_addr); end
      @(negedge clk);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      total++; if (imem_req !== 1'b0 || q_count !== 3'd0) begin bad++; $display("FAIL br_dropped got req=%0b q=%0d exp 0/0", imem_req, q_count); end
      mem_on = 1'b1;
      @(negedge clk);
      total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_new_addr got=%h exp=100", imem_addr); end
      @(negedge clk);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL br_gap got=%0b exp=0", valid); end
      @(negedge clk);
      total++; if (valid !== 1'b1 || PC !== 32'h104) begin bad++; $display("FAIL br_first_pc got=%h v=%0b exp=104", PC, valid); end
      total++; if (Instruction !== 32'hE000_0100) begin bad++; $display("FAIL br_first_instr got=%h exp=e0000100", Instruction); end
   endtask

   task automatic test_branch_ack_freeze();
      mem_on = 1'b1; mem_lat = 0;
      do_reset();
      for (int k = 0; k <= 3; k++) @(negedge clk);
      freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
      @(negedge clk);
      branch_taken = 1'b0; freeze = 1'b0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL baf_valid got=%0b exp=0", valid); end
      total++; if (q_count !== 3'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL baf_drop got q=%0d req=%0b exp 0/0", q_count, imem_req); end
      @(negedge clk);
      total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL baf_addr got=%h exp=200", imem_addr); end
      @(negedge clk); @(negedge clk);
      total++; if (valid !== 1'b1 || PC !== 32'h204 || Instruction !== 32'hE000_0200) begin bad++; $display("FAIL baf_first got pc=%h i=%h v=%0b exp 204/e0000200/1", PC, Instruction, valid); end
   endtask

   task automatic test_flush();
      mem_on = 1'b1; mem_lat = 0;
      do_reset();
      for (int k = 0; k <= 4; k++) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0b exp=0", valid); end
      total++; if (q_count !== 3'd2) begin bad++; $display("FAIL fl_qcount got=%0d exp=2", q_count); end
      @(negedge clk);
      total++; if (valid !== 1'b1 || PC !== 32'd16 || Instruction !== 32'hE000_000C) begin bad++; $display("FAIL fl_next got pc=%h i=%h v=%0b exp 10/e000000c/1", PC, Instruction, valid); end
      @(negedge clk);
      total++; if (PC !== 32'd20 || Instruction !== 32'hE000_0010) begin bad++; $display("FAIL fl_next2 got pc=%h i=%h exp 14/e0000010", PC, Instruction); end
   endtask

   task automatic test_reset_mid();
      mem_on = 1'b1; mem_lat = 3;
      do_reset();
      for (int m = 1; m <= 6; m++) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || q_count !== 3'd0) begin bad++; $display("FAIL rm_fetch got req=%0b addr=%h q=%0d exp 0/0/0", imem_req, imem_addr, q_count); end
      total++; if (valid !== 1'b0 || PC !== 32'h0 || Instruction !== 32'h0) begin bad++; $display("FAIL rm_out got v=%0b pc=%h i=%h exp 0/0/0", valid, PC, Instruction); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rm_first got req=%0b addr=%h exp 1/0", imem_req, imem_addr); end
      mem_lat = 0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_freeze();
      test_latency();
      test_branch();
      test_branch_ack_freeze();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
